spi_slave_tx_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO on the axi_aclk domain that buffers 32-bit read words between the AXI master plug's tx_data/tx_valid/tx_ready output and the SPI-side transmit path (dual-clock FIFO / shifter). It decouples single-beat AXI read latency from SPI bit timing. It discards stale prefetched words when a read transaction ends or restarts, and it flags underruns where the SPI side requests a word that is not yet available.

---
 rtl/spi_slave_tx_fifo.sv | 87 ++++++++
 tb/tb_spi_slave_tx_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave_tx_fifo.sv
// First-word-fall-through FIFO between the AXI read plug and the SPI transmit path.
// Drops prefetched words on flush and flags pops attempted while empty.
module spi_slave_tx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         axi_aclk,
    input  logic                         axi_aresetn,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         underrun
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [LW-1:0]         r_level;
    logic                  r_underrun;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    // in_ready depends only on state so the plug never sees a path from out_ready.
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = r_mem[r_rptr];
    assign level     = r_level;
    assign underrun  = r_underrun;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
                if (!axi_aresetn) begin
                    r_mem[gi] <= '0;
                end else if (w_push && !flush && (r_wptr == PW'(gi))) begin
                    r_mem[gi] <= in_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_underrun <= 1'b0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            // A same-cycle push cannot rescue a pop that found the FIFO empty.
            if (out_ready && w_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_tx_fifo.sv
// Bench for spi_slave_tx_fifo: directed steps plus random traffic checked
// against a queue-based model of the FIFO.
module tb_spi_slave_tx_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH+1);

    logic          axi_aclk;
    logic          axi_aresetn;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          underrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] m_q[$];
    logic          m_und;

    spi_slave_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .underrun    (underrun)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},  DW'(in_ready),  DW'(m_q.size() != DEPTH));
        chk({tag, ".out_valid"}, DW'(out_valid), DW'(m_q.size() != 0));
        chk({tag, ".level"},     DW'(level),     DW'(m_q.size()));
        chk({tag, ".underrun"},  DW'(underrun),  DW'(m_und));
        if (m_q.size() != 0) chk({tag, ".out_data"}, out_data, m_q[0]);
        $display("%s: in_ready=%0b out_valid=%0b level=%0d underrun=%0b out_data=%08h",
                 tag, in_ready, out_valid, level, underrun, out_data);
    endtask

    // One clock: check current outputs, drive inputs, advance, update model.
    task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                        input logic r, input logic f);
        bit was_full, was_empty;
        check_all(tag);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        @(posedge axi_aclk);
        if (f) begin
            m_q.delete();
            m_und = 1'b0;
        end else begin
            if (r && was_empty) m_und = 1'b1;
            if (r && !was_empty) void'(m_q.pop_front());
            if (v && !was_full) m_q.push_back(d);
        end
        #1;
    endtask

    initial begin
        m_und       = 1'b0;
        axi_aresetn = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        #1;
        chk("rst.out_data", out_data, 32'h0);
        repeat (2) @(posedge axi_aclk);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(posedge axi_aclk);
        #1;

        // Idle after reset
        for (int i = 0; i < 10; i++) step("idle", 1'b0, '0, 1'b0, 1'b0);

        // Single word through and out
        step("single_push", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        step("single_hold", 1'b0, '0, 1'b0, 1'b0);
        step("single_pop",  1'b0, '0, 1'b1, 1'b0);
        step("single_after", 1'b0, '0, 1'b0, 1'b0);

        // Fill, hold off fifth word, pop-while-full refuses push, then wrap drain
        for (int i = 1; i <= 4; i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b0);
        step("full_hold", 1'b1, 32'h5, 1'b0, 1'b0);
        step("full_pop",  1'b1, 32'h5, 1'b1, 1'b0);
        step("accept5",   1'b1, 32'h5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        step("drained", 1'b0, '0, 1'b0, 1'b0);

        // Concurrent push/pop at level 2
        step("conc_pre", 1'b1, 32'h100, 1'b0, 1'b0);
        step("conc_pre", 1'b1, 32'h101, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("conc", 1'b1, DW'(32'h102 + i), 1'b1, 1'b0);
        step("conc_end", 1'b0, '0, 1'b0, 1'b0);
        step("conc_flush", 1'b0, '0, 1'b0, 1'b1);

        // Underrun sets and sticks, then flush drops everything incl. flush-cycle word
        step("und_req", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("und_hold", 1'b1, DW'(32'hA0 + i), 1'b0, 1'b0);
        step("flush", 1'b1, 32'hBAD0BAD0, 1'b0, 1'b1);
        step("post_flush", 1'b0, '0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), $urandom(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        end
        step("pre_rst_flush", 1'b0, '0, 1'b0, 1'b1);

        // Asynchronous reset mid-stream at level 3
        for (int i = 0; i < 3; i++) step("rst_fill", 1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
        check_all("rst_before");
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        axi_aresetn = 1'b0;
        #1;
        chk("async.out_valid", DW'(out_valid), 32'h0);
        chk("async.level",     DW'(level),     32'h0);
        chk("async.in_ready",  DW'(in_ready),  32'h1);
        chk("async.out_data",  out_data,       32'h0);
        m_q.delete();
        m_und = 1'b0;
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(posedge axi_aclk);
        #1;
        step("post_rst", 1'b0, '0, 1'b0, 1'b0);
        step("post_rst_push", 1'b1, 32'h12345678, 1'b0, 1'b0);
        step("post_rst_pop", 1'b0, '0, 1'b1, 1'b0);
        step("post_rst_end", 1'b0, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
